// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter and its ALU.
package alu_arb_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned TYPE_W  = 2;
   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned ALU_W   = 32;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 4'h0,
      OP_SUB = 4'h1,
      OP_AND = 4'h2,
      OP_OR  = 4'h3,
      OP_XOR = 4'h4,
      OP_SLL = 4'h5,
      OP_SRL = 4'h6,
      OP_MOV = 4'h7
   } alu_op_e;

   // TY_PASS2/TY_PASS1 forward an operand unchanged (load-immediate / move paths).
   typedef enum logic [TYPE_W-1:0] {
      TY_ALU   = 2'd0,
      TY_PASS2 = 2'd1,
      TY_PASS1 = 2'd2,
      TY_RSVD  = 2'd3
   } alu_type_e;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [TYPE_W-1:0] type_code;
      logic              is_imm;
      logic [ALU_W-1:0]  imm;
      logic [ALU_W-1:0]  rh;
      logic [ALU_W-1:0]  ro;
      logic              id;
   } arb_op_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the share arbiter.
interface alu_share_arbiter_if;
   import alu_arb_pkg::*;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0][OPC_W-1:0]  req_opcode;
   logic [NUM_REQ-1:0][TYPE_W-1:0] req_type;
   logic [NUM_REQ-1:0]             req_is_imm;
   logic [NUM_REQ-1:0][ALU_W-1:0]  req_imm;
   logic [NUM_REQ-1:0][ALU_W-1:0]  req_rh;
   logic [NUM_REQ-1:0][ALU_W-1:0]  req_ro;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic                           rsp_id;
   logic [ALU_W-1:0]               rsp_result;
   logic                           rsp_zero;
   logic                           rsp_negative;
   logic                           busy;

   modport master (
      output req_valid, req_opcode, req_type, req_is_imm, req_imm, req_rh, req_ro, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, busy
   );

   modport slave (
      input  req_valid, req_opcode, req_type, req_is_imm, req_imm, req_rh, req_ro, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, busy
   );

endinterface

// File: rtl/ALUControl.sv
// Shared single-cycle ALU datapath: operand-2 select, operation, N/Z flags.
module ALUControl
   import alu_arb_pkg::*;
(
   input  logic [OPC_W-1:0]  opcode,
   input  logic [TYPE_W-1:0] type_code,
   input  logic              is_imm,
   input  logic [ALU_W-1:0]  imm,
   input  logic [ALU_W-1:0]  rh,
   input  logic [ALU_W-1:0]  ro,
   output logic [ALU_W-1:0]  result,
   output logic              zero,
   output logic              negative,
   output logic [ALU_W-1:0]  r1_value,
   output logic [ALU_W-1:0]  r2_value
);

   logic [ALU_W-1:0] op2;
   logic [ALU_W-1:0] alu_c;

   always_comb begin
      op2   = is_imm ? imm : ro;
      alu_c = '0;
      case (opcode)
         OP_ADD:  alu_c = rh + op2;
         OP_SUB:  alu_c = rh - op2;
         OP_AND:  alu_c = rh & op2;
         OP_OR:   alu_c = rh | op2;
         OP_XOR:  alu_c = rh ^ op2;
         OP_SLL:  alu_c = rh << op2[4:0];
         OP_SRL:  alu_c = rh >> op2[4:0];
         OP_MOV:  alu_c = op2;
         default: alu_c = '0;
      endcase

      result = '0;
      case (type_code)
         TY_PASS2: result = op2;
         TY_PASS1: result = rh;
         default:  result = alu_c;
      endcase

      zero     = (result == '0);
      negative = result[ALU_W-1];
      r1_value = rh;
      r2_value = op2;
   end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational 2-way round-robin picker; on contention the requester not granted last wins.
module alu_rr_pick (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       any
);

   always_comb begin
      grant[0] = req_valid[0] & (~req_valid[1] | last_grant);
      grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant);
      any      = |req_valid;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALUControl between two requesters: accept, one-cycle execute, registered response.
// Optional per-requester accept counters when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic                stats_clr,
   output logic [CNT_W-1:0]    grant_cnt0,
   output logic [CNT_W-1:0]    grant_cnt1
`endif
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   arb_op_t           op_q, op_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_neg_q, rsp_neg_d;

   logic [1:0]        grant;
   logic              any_valid;
   logic              win_id;
   logic              accept;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_neg;
   logic [ALU_W-1:0]  r1_unused;
   logic [ALU_W-1:0]  r2_unused;

   alu_rr_pick u_pick (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .any        (any_valid)
   );

   assign win_id = grant[1];

   ALUControl u_alu (
      .opcode    (op_q.opcode),
      .type_code (op_q.type_code),
      .is_imm    (op_q.is_imm),
      .imm       (op_q.imm),
      .rh        (op_q.rh),
      .ro        (op_q.ro),
      .result    (alu_result),
      .zero      (alu_zero),
      .negative  (alu_neg),
      .r1_value  (r1_unused),
      .r2_value  (r2_unused)
   );

   // Next state, operand capture and response capture.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      op_d          = op_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_neg_d     = rsp_neg_q;
      accept        = 1'b0;
      bus.req_ready = '0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = op_q.id;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_neg_d    = alu_neg;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            // Response retires this cycle; a waiting request is taken in the same cycle.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (any_valid) begin
                  accept  = 1'b1;
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         bus.req_ready     = grant;
         last_grant_d      = win_id;
         op_d.opcode       = bus.req_opcode[win_id];
         op_d.type_code    = bus.req_type[win_id];
         op_d.is_imm       = bus.req_is_imm[win_id];
         op_d.imm          = bus.req_imm[win_id];
         op_d.rh           = bus.req_rh[win_id];
         op_d.ro           = bus.req_ro[win_id];
         op_d.id           = win_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_neg_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_neg_q    <= rsp_neg_d;
      end
   end

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_zero     = rsp_zero_q;
   assign bus.rsp_negative = rsp_neg_q;
   assign bus.busy         = (state_q != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Clear has priority over a same-cycle accept; counters wrap naturally.
   always_comb begin
      cnt0_d = cnt0_q + CNT_W'(accept & ~win_id);
      cnt1_d = cnt1_q + CNT_W'(accept & win_id);
      if (stats_clr) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared ALU datapath. It wraps one `ALUControl` instance so that the execute stage (requester 0) and the address/auxiliary unit (requester 1) can share it. Each operation is accepted with a valid/ready handshake, its operands are registered, and it executes for one cycle. The result and N/Z flags are returned through a registered response channel that accepts backpressure, tagged with the requester id.

## Interface
- Parameters:
- `DATA_W`, 32, operand/result width; must match `ALUControl` (only 32 supported).
- Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester request valid, bit i = requester i.
- `req_ready` out 2: per-requester accept, one-hot or zero.
- `req_opcode` in 2x4: OpCode per requester.
- `req_type` in 2x2: TypeCode per requester.
- `req_is_imm` in 2: immediate select per requester.
- `req_imm` in 2x32: immediate value per requester.
- `req_rh` in 2x32: first operand (Rh) per requester.
- `req_ro` in 2x32: second register operand (Ro) per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out 1: requester id of the response.
- `rsp_result` out 32: ALU result.
- `rsp_zero` out 1: zero flag.
- `rsp_negative` out 1: negative flag.
- `busy` out 1: high in every state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, pick a winner and assert its `req_ready` combinationally.
  - Capture the winner's opcode/type/is_imm/imm/rh/ro and its id into the operand register; go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - The operand register drives `ALUControl`.
  - At the clock edge, capture result/zero/negative/id into the response register, set `rsp_valid`, go to RESP.
  - `req_ready` is 0.
- RESP:
  - `rsp_valid` is held and the response fields are stable until `rsp_ready` is seen.
  - On `rsp_ready` with a pending `req_valid`: arbitrate, accept the winner in this same cycle, go to EXEC (back-to-back).
  - On `rsp_ready` with no pending request: go to IDLE.
  - Without `rsp_ready`: `req_ready` is 0.
- Arbitration is round-robin on a 1-bit `last_grant` register:
  - A single valid requester always wins.
  - With both valid, the requester not equal to `last_grant` wins.
  - `last_grant` updates on every accept.
- Requesters must hold their request fields stable while `req_valid` is high and `req_ready` is low. A requester may drop `req_valid` before it is granted; that request is simply not served.
- Operand 2 selection (immediate vs Ro) is performed inside `ALUControl`. Its `r1_value`/`r2_value` outputs are left unused.
- Flags come from the response register only. No architectural flag state is kept here.

## Timing
- Reset values:
  - State IDLE.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - `rsp_valid` = 0; `rsp_id`, `rsp_result`, `rsp_zero`, `rsp_negative` = 0.
  - `req_ready` = 0; `busy` = 0.
- Latency: accept in cycle T; `rsp_valid` high in cycle T+2.
- Throughput: one operation per 2 cycles with `rsp_ready` tied high.
- Backpressure: the response holds indefinitely. Requests are not accepted while a response is pending (single outstanding operation).
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and `rsp_valid` drops immediately with `rst_n`.
- A request and a response handshake in the same cycle in RESP is legal and required to work.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1`, 16 bits each, counting accepts per requester.
  - Counters reset to 0 and wrap from 0xFFFF to 0x0000.
  - Adds input `stats_clr`, a synchronous clear of both counters. An accept in the same cycle as `stats_clr` yields a count of 0 (clear wins).
- Not defined: the counters and their ports do not exist. Behaviour is otherwise identical.

## Structure
- Package `alu_arb_pkg`:
  - state enum (IDLE, EXEC, RESP);
  - `OPC_W`=4, `TYPE_W`=2, `NUM_REQ`=2;
  - an operand-bundle struct (opcode, type, is_imm, imm, rh, ro, id).
- Sub-module `alu_rr_pick`: combinational 2-way round-robin picker. Inputs: `req_valid`, `last_grant`. Outputs: one-hot grant and `any`.
- One `ALUControl` instance inside the top.

## Test plan
- Only req0 valid, opcode ADD, rh=5, ro=7, is_imm=0 → `req_ready[0]` high in cycle T; `rsp_valid` at T+2 with result=12, zero=0, negative=0, id=0.
- Both valid from reset → req0 served first, then req1 back-to-back with `rsp_ready`=1; `rsp_id` sequence 0,1,0,1 while both stay valid.
- req1 SUB with is_imm=1, imm=9, rh=9, ro=0x1234 → result=0, zero=1; the Ro value is ignored.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and fields stable, `req_ready`=0 throughout; response completes on the first `rsp_ready` cycle.
- `rst_n` asserted during EXEC → `rsp_valid`=0 immediately; after release, the first contention is won by req0.
- With `ALU_ARB_STATS_EN`: 3 accepts for req0 and 2 for req1 → `grant_cnt0`=3, `grant_cnt1`=2; `stats_clr` → both 0.
